// File: rtl/uart_tx.sv
// Serial transmitter: one 32-bit word out as four UART frames, most significant byte first.
// Define UART_TX_PARITY_EN to insert an even-parity bit after bit 7 of every byte.

module uart_tx #(
    parameter int FREQUENCY_IN_HZ = 50_000_000,
    parameter int BAUD            = 9600
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        io_word_valid,
    input  logic [31:0] io_word,
    output logic        io_ready,
    output logic        io_tx,
    output logic        io_done
);

    localparam int CLKS_PER_BIT = FREQUENCY_IN_HZ / BAUD;
    localparam int CW           = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY_BIT = 3'd3,
        STOP       = 3'd4
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   baud_q;
    logic [CW-1:0]   baud_d;
    logic [2:0]      bit_q;
    logic [1:0]      byte_q;
    logic [31:0]     word_q;
    logic            tx_q;
    logic            ready_q;
    logic            done_q;
    logic            bitEnd;
    logic [7:0]      curByte;

    // The byte on the wire always sits in the top of the word register; later bytes shift up.
    always_comb begin
        bitEnd  = (baud_q == BAUD_LAST);
        baud_d  = bitEnd ? '0 : baud_q + CW'(1);
        curByte = word_q[31:24];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            word_q  <= '0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    baud_q <= '0;
                    bit_q  <= '0;
                    byte_q <= '0;
                    tx_q   <= 1'b1;
                    if (io_word_valid && ready_q) begin
                        word_q  <= io_word;
                        state_q <= START;
                        tx_q    <= 1'b0;
                        ready_q <= 1'b0;
                    end
                end

                START: begin
                    baud_q <= baud_d;
                    if (bitEnd) begin
                        state_q <= DATA;
                        bit_q   <= '0;
                        tx_q    <= curByte[0];
                    end
                end

                DATA: begin
                    baud_q <= baud_d;
                    if (bitEnd) begin
                        if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY_BIT;
                            tx_q    <= ^curByte;
`else
                            state_q <= STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_q <= bit_q + 3'd1;
                            tx_q  <= curByte[bit_q + 3'd1];
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY_BIT: begin
                    baud_q <= baud_d;
                    if (bitEnd) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end
                end
`endif

                STOP: begin
                    baud_q <= baud_d;
                    bit_q  <= '0;
                    if (bitEnd) begin
                        if (byte_q == 2'd3) begin
                            // Ready and done rise together so a new word can follow immediately.
                            state_q <= IDLE;
                            byte_q  <= '0;
                            ready_q <= 1'b1;
                            done_q  <= 1'b1;
                            tx_q    <= 1'b1;
                        end else begin
                            state_q <= START;
                            byte_q  <= byte_q + 2'd1;
                            word_q  <= word_q << 8;
                            tx_q    <= 1'b0;
                        end
                    end
                end

                default: begin
                    state_q <= IDLE;
                    baud_q  <= '0;
                    bit_q   <= '0;
                    byte_q  <= '0;
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign io_tx    = tx_q;
    assign io_ready = ready_q;
    assign io_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with a short bit period; an independent line decoder rebuilds bytes.
// Honours UART_TX_PARITY_EN the same way the design does.

module tb_uart_tx;

    localparam int FREQ = 160;
    localparam int BRATE = 10;
    localparam int C = 16;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    localparam int WORD_CYC = 4 * FB * C;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        io_word_valid;
    logic [31:0] io_word;
    logic        io_ready;
    logic        io_tx;
    logic        io_done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    uart_tx #(.FREQUENCY_IN_HZ(FREQ), .BAUD(BRATE)) dut (
        .clk(clk),
        .reset_n(reset_n),
        .io_word_valid(io_word_valid),
        .io_word(io_word),
        .io_ready(io_ready),
        .io_tx(io_tx),
        .io_done(io_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder: finds each falling edge, samples mid-bit, collects bytes and parity bits.
    logic [7:0] rxBytes[$];
    logic       rxPar[$];
    int         frameErr = 0;
    int         doneCount = 0;
    bit         busy = 1'b0;
    int         cnt = 0;
    int         monK = 0;
    logic [7:0] sh = '0;

    always @(negedge clk) begin
        if (io_done === 1'b1) doneCount++;
        if (reset_n !== 1'b1) begin
            busy = 1'b0;
        end else if (!busy) begin
            if (io_tx === 1'b0) begin
                busy = 1'b1;
                cnt = 0;
            end
        end else begin
            cnt++;
        end
        if (busy && (cnt % C) == C / 2) begin
            monK = cnt / C;
            if (monK == 0) begin
                if (io_tx !== 1'b0) frameErr++;
            end else if (monK <= 8) begin
                sh[monK-1] = io_tx;
            end else if (monK == FB - 1) begin
                if (io_tx !== 1'b1) frameErr++;
                rxBytes.push_back(sh);
                busy = 1'b0;
            end else begin
                rxPar.push_back(io_tx);
                if (io_tx !== ^sh) frameErr++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] w, output int startAt);
        @(negedge clk);
        io_word_valid = 1'b1;
        io_word = w;
        @(negedge clk);
        startAt = cyc;
        checkOutput("accept tx low", {63'd0, io_tx}, 64'd0);
        checkOutput("accept ready low", {63'd0, io_ready}, 64'd0);
        io_word_valid = 1'b0;
    endtask

    task automatic waitDone(output int at, output int readyHigh);
        at = -1;
        readyHigh = 0;
        for (int i = 0; i < WORD_CYC + 200; i++) begin
            @(negedge clk);
            if (io_done === 1'b1) begin
                at = cyc;
                break;
            end
            if (io_ready !== 1'b0) readyHigh++;
        end
        checkOutput("done seen", {63'd0, at >= 0}, 64'd1);
        checkOutput("ready at done", {63'd0, io_ready}, 64'd1);
    endtask

    function automatic logic [31:0] rxWord(input int base);
        return {rxBytes[base], rxBytes[base+1], rxBytes[base+2], rxBytes[base+3]};
    endfunction

    int s1, s2, d1, d2, rh, d0, bad, target;

    initial begin
        reset_n = 1'b0;
        io_word_valid = 1'b0;
        io_word = '0;

        repeat (3) @(negedge clk);
        checkOutput("reset tx", {63'd0, io_tx}, 64'd1);
        checkOutput("reset ready", {63'd0, io_ready}, 64'd1);
        checkOutput("reset done", {63'd0, io_done}, 64'd0);
        reset_n = 1'b1;

        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (io_tx !== 1'b1 || io_ready !== 1'b1 || io_done !== 1'b0) bad++;
        end
        checkOutput("idle outputs", 64'(bad), 64'd0);

        // Single word.
        rxBytes.delete();
        rxPar.delete();
        d0 = doneCount;
        applyStimulus(32'h00A00093, s1);
        waitDone(d1, rh);
        checkOutput("single ready low span", 64'(rh), 64'd0);
        checkOutput("single duration", 64'(d1 - s1), 64'(WORD_CYC));
        @(negedge clk);
        checkOutput("done one cycle", {63'd0, io_done}, 64'd0);
        checkOutput("single byte count", 64'(rxBytes.size()), 64'd4);
        checkOutput("single byte1 A0", {56'd0, rxBytes[1]}, 64'hA0);
        checkOutput("single word", {32'd0, rxWord(0)}, 64'h00A00093);
        checkOutput("single framing", 64'(frameErr), 64'd0);
        checkOutput("single done count", 64'(doneCount - d0), 64'd1);
`ifdef UART_TX_PARITY_EN
        checkOutput("parity bits 00A00093",
                    {60'd0, rxPar[0], rxPar[1], rxPar[2], rxPar[3]}, 64'd0);
`endif

        // Back-to-back, valid held high, second word offered on the done cycle.
        repeat (5) @(negedge clk);
        rxBytes.delete();
        d0 = doneCount;
        io_word_valid = 1'b1;
        io_word = 32'h01400113;
        @(negedge clk);
        s1 = cyc;
        checkOutput("b2b first start", {63'd0, io_tx}, 64'd0);
        waitDone(d1, rh);
        io_word = 32'h002081B3;
        @(negedge clk);
        s2 = cyc;
        checkOutput("b2b second start tx", {63'd0, io_tx}, 64'd0);
        checkOutput("b2b gap", 64'(s2 - d1), 64'd1);
        io_word_valid = 1'b0;
        waitDone(d2, rh);
        checkOutput("b2b duration 1", 64'(d1 - s1), 64'(WORD_CYC));
        checkOutput("b2b duration 2", 64'(d2 - s2), 64'(WORD_CYC));
        @(negedge clk);
        checkOutput("b2b byte count", 64'(rxBytes.size()), 64'd8);
        checkOutput("b2b word 1", {32'd0, rxWord(0)}, 64'h01400113);
        checkOutput("b2b word 2", {32'd0, rxWord(4)}, 64'h002081B3);
        checkOutput("b2b done count", 64'(doneCount - d0), 64'd2);

        // Busy ignore: extra word offered during byte 2.
        repeat (5) @(negedge clk);
        rxBytes.delete();
        d0 = doneCount;
        applyStimulus(32'h08000313, s1);
        target = s1 + 2 * FB * C + 3 * C;
        while (cyc < target) @(negedge clk);
        io_word_valid = 1'b1;
        io_word = 32'hFFFFFFFF;
        @(negedge clk);
        io_word_valid = 1'b0;
        waitDone(d1, rh);
        repeat (3 * FB * C) @(negedge clk);
        checkOutput("busy byte count", 64'(rxBytes.size()), 64'd4);
        checkOutput("busy word", {32'd0, rxWord(0)}, 64'h08000313);
        checkOutput("busy done count", 64'(doneCount - d0), 64'd1);
        checkOutput("busy line idle", {63'd0, io_tx}, 64'd1);

        // Reset during byte 1 data bit 2 (a zero bit of 0x53).
        rxBytes.delete();
        d0 = doneCount;
        applyStimulus(32'h00532023, s1);
        target = s1 + FB * C + 3 * C + C / 2;
        while (cyc < target) @(negedge clk);
        checkOutput("pre-reset tx low", {63'd0, io_tx}, 64'd0);
        reset_n = 1'b0;
        #1;
        checkOutput("async reset tx", {63'd0, io_tx}, 64'd1);
        checkOutput("async reset ready", {63'd0, io_ready}, 64'd1);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        repeat (WORD_CYC) @(negedge clk);
        checkOutput("reset no done", 64'(doneCount - d0), 64'd0);
        checkOutput("reset ready after", {63'd0, io_ready}, 64'd1);
        rxBytes.delete();
        frameErr = 0;
        applyStimulus(32'h00532023, s1);
        waitDone(d1, rh);
        @(negedge clk);
        checkOutput("post-reset word", {32'd0, rxWord(0)}, 64'h00532023);
        checkOutput("post-reset framing", 64'(frameErr), 64'd0);

`ifdef UART_TX_PARITY_EN
        repeat (5) @(negedge clk);
        rxBytes.delete();
        rxPar.delete();
        applyStimulus(32'h01000000, s1);
        waitDone(d1, rh);
        @(negedge clk);
        checkOutput("parity first byte", {63'd0, rxPar[0]}, 64'd1);
        checkOutput("parity duration", 64'(d1 - s1), 64'(44 * C));
        checkOutput("parity word", {32'd0, rxWord(0)}, 64'h01000000);
`endif

        repeat (5) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
